// File: rtl/sound_sched_pkg.sv
// Shared types and constants for the sound scheduler: state encoding,
// SoundSelect codes and default frame counts.
package sound_pkg;

    localparam int unsigned COIN_FRAMES_DEF = 12;
    localparam int unsigned END_FRAMES_DEF  = 180;
    localparam int unsigned QDEPTH_DEF      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COIN = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    localparam logic [2:0] SND_SILENCE = 3'b000;
    localparam logic [2:0] SND_LOSE    = 3'b001;
    localparam logic [2:0] SND_WIN     = 3'b010;
    localparam logic [2:0] SND_COIN    = 3'b100;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] state_code(input state_t s);
        logic [2:0] code;
        case (s)
            ST_COIN: code = SND_COIN;
            ST_WIN:  code = SND_WIN;
            ST_LOSE: code = SND_LOSE;
            default: code = SND_SILENCE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sound_sched_frame_tick.sv
// Brings the vertical-sync frame clock into the Clk domain and emits a
// single-cycle tick on each of its rising edges.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic       sync1;
    logic       sync2;
    logic       sync2_d;
    logic [2:0] fill;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            fill    <= '0;
        end else begin
            sync1   <= frame_clk;
            sync2   <= sync1;
            sync2_d <= sync2;
            fill    <= {fill[1:0], 1'b1};
        end
    end

    // Suppress ticks until every stage holds a real sample, so a frame_clk
    // already high at reset release is not mistaken for an edge.
    assign tick = fill[2] & sync2 & ~sync2_d;

endmodule

// File: rtl/sound_sched.sv
// Sound scheduler: arbitrates coin chimes and win/lose jingles onto SoundSelect.
// Define SOUND_SCHED_COIN_QUEUE_EN to queue coin requests made while a chime plays.
module sound_sched
    import sound_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = COIN_FRAMES_DEF,
    parameter int unsigned END_FRAMES  = END_FRAMES_DEF,
    parameter int unsigned QDEPTH      = QDEPTH_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       coin_collide,
    input  logic [4:0] status,
    output logic [2:0] SoundSelect,
    output logic       busy,
    output logic [1:0] pending
);

    localparam int unsigned TW = $clog2(max_u(COIN_FRAMES, END_FRAMES)) + 1;
    localparam logic [TW-1:0] COIN_LOAD = TW'(COIN_FRAMES);
    localparam logic [TW-1:0] END_LOAD  = TW'(END_FRAMES);
    localparam logic [2:0]    QMAX      = 3'(QDEPTH);
`ifdef SOUND_SCHED_COIN_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    state_t      state, n_state;
    logic [TW-1:0] timer, n_timer;
    logic [1:0]  n_pend;
    logic [2:0]  pend_sum;
    logic        n_gap;
    logic        tick, expire;
    logic        armed, coin_d;
    logic [1:0]  st_d;
    logic        coin_rise, win_rise, lose_rise, win_fall, lose_fall;
    logic        status_unused;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign status_unused = ^status[4:2];

    // armed masks the first post-reset cycle so held-high inputs are not edges
    assign coin_rise = armed & coin_collide & ~coin_d;
    assign win_rise  = armed & status[1] & ~st_d[1];
    assign lose_rise = armed & status[0] & ~st_d[0];
    assign win_fall  = st_d[1] & ~status[1];
    assign lose_fall = st_d[0] & ~status[0];
    assign expire    = tick && (timer <= TW'(1));

    function automatic logic [1:0] sat(input logic [2:0] v);
        return (v > QMAX) ? QMAX[1:0] : v[1:0];
    endfunction

    always_comb begin
        n_state  = state;
        n_timer  = timer;
        n_pend   = pending;
        n_gap    = 1'b0;
        pend_sum = {1'b0, pending} + {2'b00, coin_rise & QUEUE_EN};
        if (lose_rise) begin
            n_state = ST_LOSE;
            n_timer = END_LOAD;
            n_pend  = '0;
        end else if (win_rise) begin
            n_state = ST_WIN;
            n_timer = END_LOAD;
            n_pend  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending != '0) begin
                        n_state = ST_COIN;
                        n_timer = COIN_LOAD;
                        n_pend  = sat(pend_sum - 3'd1);
                    end else if (coin_rise) begin
                        n_state = ST_COIN;
                        n_timer = COIN_LOAD;
                    end
                end
                ST_COIN: begin
                    n_pend = sat(pend_sum);
                    if (!QUEUE_EN && coin_rise) begin
                        n_timer = COIN_LOAD;
                    end else if (expire) begin
                        if (pend_sum != '0) begin
                            n_timer = COIN_LOAD;
                            n_pend  = sat(pend_sum - 3'd1);
                            n_gap   = 1'b1;
                        end else begin
                            n_state = ST_IDLE;
                            n_timer = '0;
                        end
                    end else if (tick) begin
                        n_timer = timer - TW'(1);
                    end
                end
                ST_WIN: begin
                    if (win_fall || expire) begin
                        n_state = ST_IDLE;
                        n_timer = '0;
                    end else if (tick) begin
                        n_timer = timer - TW'(1);
                    end
                end
                ST_LOSE: begin
                    if (lose_fall || expire) begin
                        n_state = ST_IDLE;
                        n_timer = '0;
                    end else if (tick) begin
                        n_timer = timer - TW'(1);
                    end
                end
                default: begin
                    n_state = ST_IDLE;
                    n_timer = '0;
                    n_pend  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            pending     <= '0;
            SoundSelect <= SND_SILENCE;
            armed       <= 1'b0;
            coin_d      <= 1'b0;
            st_d        <= '0;
        end else begin
            state       <= n_state;
            timer       <= n_timer;
            pending     <= n_pend;
            SoundSelect <= n_gap ? SND_SILENCE : state_code(n_state);
            armed       <= 1'b1;
            coin_d      <= coin_collide;
            st_d        <= status[1:0];
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sound_sched.sv
// Directed scoreboard bench for sound_sched: expectations are queued as
// stimulus is applied and checked once the DUT has had its clock edge.
`timescale 1ns/1ps
module tb_sound_sched;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       coin_collide;
    logic [4:0] status;
    logic [2:0] SoundSelect;
    logic       busy;
    logic [1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic       busy;
        logic [1:0] pend;
    } exp_t;
    exp_t sb[$];

    sound_sched #(.COIN_FRAMES(12), .END_FRAMES(180), .QDEPTH(3)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .coin_collide (coin_collide),
        .status       (status),
        .SoundSelect  (SoundSelect),
        .busy         (busy),
        .pending      (pending)
    );

    always #10 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_out(input string tag, input logic [2:0] sel,
                              input logic b, input logic [1:0] p);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.busy = b;
        e.pend = p;
        sb.push_back(e);
    endtask

    task automatic cmp3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp3({e.tag, ".sel"},  SoundSelect,       e.sel);
            cmp3({e.tag, ".busy"}, {2'b00, busy},     {2'b00, e.busy});
            cmp3({e.tag, ".pend"}, {1'b0, pending},   {1'b0, e.pend});
        end
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        steps(3);
        frame_clk = 1'b0;
        steps(3);
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) frame_pulse();
    endtask

    task automatic coin_pulse(input string tag, input logic [2:0] sel,
                              input logic b, input logic [1:0] p);
        coin_collide = 1'b1;
        expect_out(tag, sel, b, p);
        step();
        check_out();
        coin_collide = 1'b0;
        step();
    endtask

    initial begin
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        coin_collide = 1'b0;
        status       = 5'b00100;
        steps(2);
        expect_out("reset", 3'b000, 1'b0, 2'd0);
        check_out();
        Reset = 1'b0;
        steps(4);

        // single chime: 1-cycle latency, 12 frames long
        coin_collide = 1'b1;
        expect_out("coin_pre", 3'b000, 1'b0, 2'd0);
        check_out();
        expect_out("coin_start", 3'b100, 1'b1, 2'd0);
        step();
        check_out();
        coin_collide = 1'b0;
        step();
        frame_pulses(11);
        expect_out("coin_f11", 3'b100, 1'b1, 2'd0);
        check_out();
        frame_pulse();
        expect_out("coin_f12", 3'b000, 1'b0, 2'd0);
        check_out();

        // win preempts a playing chime and runs 180 frames
        coin_pulse("coin2_start", 3'b100, 1'b1, 2'd0);
        frame_pulses(3);
        status = 5'b00010;
        expect_out("win_preempt", 3'b010, 1'b1, 2'd0);
        step();
        check_out();
        frame_pulses(179);
        expect_out("win_f179", 3'b010, 1'b1, 2'd0);
        check_out();
        frame_pulse();
        expect_out("win_f180", 3'b000, 1'b0, 2'd0);
        check_out();
        status = 5'b00100;
        expect_out("win_fall_idle", 3'b000, 1'b0, 2'd0);
        step();
        check_out();

        // simultaneous win and lose: lose wins; lose bit falling restarts
        status = 5'b00011;
        expect_out("lose_prio", 3'b001, 1'b1, 2'd0);
        step();
        check_out();
        frame_pulses(5);
        status = 5'b00100;
        expect_out("lose_fall", 3'b000, 1'b0, 2'd0);
        step();
        check_out();

        // win entry discards a coincident coin request
        status       = 5'b00010;
        coin_collide = 1'b1;
        expect_out("win_over_coin", 3'b010, 1'b1, 2'd0);
        step();
        check_out();
        coin_collide = 1'b0;
        step();
        frame_pulses(50);
        expect_out("win_f50", 3'b010, 1'b1, 2'd0);
        check_out();
        status = 5'b00100;
        expect_out("win_restart", 3'b000, 1'b0, 2'd0);
        step();
        check_out();
        steps(2);

`ifdef SOUND_SCHED_COIN_QUEUE_EN
        // five quick requests: pending saturates at 3, four chimes with gaps
        coin_pulse("q_req1", 3'b100, 1'b1, 2'd0);
        coin_pulse("q_req2", 3'b100, 1'b1, 2'd1);
        coin_pulse("q_req3", 3'b100, 1'b1, 2'd2);
        coin_pulse("q_req4", 3'b100, 1'b1, 2'd3);
        coin_pulse("q_req5", 3'b100, 1'b1, 2'd3);
        for (int c = 0; c < 4; c++) begin
            frame_pulses(11);
            expect_out($sformatf("q_chime%0d_hold", c), 3'b100, 1'b1, 2'(3 - c));
            check_out();
            frame_clk = 1'b1;
            steps(3);
            if (c < 3) begin
                expect_out($sformatf("q_chime%0d_gap", c), 3'b000, 1'b1, 2'(2 - c));
                check_out();
                step();
                expect_out($sformatf("q_chime%0d_next", c), 3'b100, 1'b1, 2'(2 - c));
                check_out();
            end else begin
                expect_out("q_done", 3'b000, 1'b0, 2'd0);
                check_out();
                step();
                expect_out("q_done_hold", 3'b000, 1'b0, 2'd0);
                check_out();
            end
            frame_clk = 1'b0;
            steps(2);
        end

        coin_pulse("r_req1", 3'b100, 1'b1, 2'd0);
        coin_pulse("r_req2", 3'b100, 1'b1, 2'd1);
        coin_pulse("r_req3", 3'b100, 1'b1, 2'd2);
`else
        // without the queue a second request restarts the chime timer
        coin_pulse("rs_start", 3'b100, 1'b1, 2'd0);
        frame_pulses(8);
        coin_pulse("rs_restart", 3'b100, 1'b1, 2'd0);
        frame_pulses(11);
        expect_out("rs_f11", 3'b100, 1'b1, 2'd0);
        check_out();
        frame_pulse();
        expect_out("rs_f12", 3'b000, 1'b0, 2'd0);
        check_out();

        coin_pulse("r_req1", 3'b100, 1'b1, 2'd0);
`endif

        // asynchronous reset mid-chime, coin held high across release
        frame_pulses(2);
        #4;
        Reset = 1'b1;
        expect_out("rst_async", 3'b000, 1'b0, 2'd0);
        #1;
        check_out();
        coin_collide = 1'b1;
        steps(2);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out($sformatf("rst_release%0d", i), 3'b000, 1'b0, 2'd0);
            check_out();
        end
        frame_pulse();
        expect_out("rst_after_frame", 3'b000, 1'b0, 2'd0);
        check_out();
        coin_collide = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_sched.md
SOUND_SCHED -- requirements
Module: sound_sched

Interface
REQ-001 Parameter COIN_FRAMES, default 12: frames a coin chime holds its select code.
REQ-002 Parameter END_FRAMES, default 180: frames a win/lose jingle holds its select code.
REQ-003 Parameter QDEPTH, default 3: saturation limit of the pending-coin counter.
REQ-004 Clk  input  1  system clock (50 MHz); the block's only clock.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_clk  input  1  VGA vertical sync, asynchronous to Clk, ~60 Hz.
REQ-007 coin_collide  input  1  level; each rising edge is one coin request.
REQ-008 status  input  5  game state one-hot {selecting, waiting, playing, win, lose}.
REQ-009 SoundSelect  output  3  registered code to the audio block: 000 silence, 001 lose, 010 win, 100 coin.
REQ-010 busy  output  1  high while state is not IDLE.
REQ-011 pending  output  2  current pending-coin count.

Function
REQ-012 A frame tick SHALL be one Clk-cycle pulse on each rising edge of frame_clk, detected after a 2-flop synchronizer.
REQ-013 Coin request and win/lose entry SHALL be rising edges of coin_collide, status[1] and status[0], sampled on Clk.
REQ-014 States SHALL be IDLE, COIN, WIN, LOSE; SoundSelect SHALL be 000, 100, 010, 001 respectively, registered.
REQ-015 SoundSelect SHALL change on the Clk edge after the cycle in which the triggering event is sampled (1-cycle latency).
REQ-016 Priority for simultaneous events SHALL be lose > win > coin.
REQ-017 Any state, on lose entry -> LOSE; on win entry with no lose entry -> WIN; frame timer loads END_FRAMES; pending clears to 0.
REQ-018 IDLE with pending > 0 -> COIN; timer loads COIN_FRAMES; pending decrements by 1 in the same cycle.
REQ-019 A coin request in IDLE with pending = 0 SHALL enter COIN directly without incrementing pending.
REQ-020 Coin requests in COIN SHALL increment pending, saturating at QDEPTH; excess requests are dropped.
REQ-021 Coin requests in WIN/LOSE and in the cycle of a win/lose entry SHALL be discarded.
REQ-022 Timer SHALL decrement by 1 per frame tick; the state SHALL exit on the tick that brings it to 0.
REQ-023 On COIN expiry with pending > 0: reload COIN_FRAMES, decrement pending, remain in COIN; SoundSelect SHALL drop to 000 for exactly one Clk cycle to retrigger the audio block.
REQ-024 On COIN expiry with pending = 0 -> IDLE.
REQ-025 WIN/LOSE SHALL exit to IDLE on timer expiry, or immediately when the matching status bit falls (restart).
REQ-026 A coin request coincident with a coin increment and a dequeue SHALL leave pending unchanged.

Reset
REQ-027 On Reset: state IDLE, SoundSelect 000, busy 0, pending 0, timer 0, synchronizer and edge-detect flops 0.
REQ-028 Reset asserted mid-jingle SHALL silence output asynchronously; no request SHALL be replayed after deassertion.
REQ-029 Edge detectors SHALL NOT report an edge on the first cycle after reset for inputs that are already high.

Configuration
REQ-030 Macro SOUND_SCHED_COIN_QUEUE_EN defined: pending-coin queue behaves as REQ-018 to REQ-023.
REQ-031 Macro undefined: pending is held at 0; coin requests in COIN restart the timer at COIN_FRAMES instead; REQ-023 retrigger gap is absent.

Structure
REQ-032 Package sound_pkg SHALL hold the state enum, the four SoundSelect code constants, and default COIN_FRAMES/END_FRAMES/QDEPTH.
REQ-033 Sub-module frame_tick SHALL hold the frame_clk synchronizer and rising-edge pulse generator.
REQ-034 Timer width SHALL be sized by $clog2 of the larger frame count plus 1.

Verification
REQ-035 Single coin_collide pulse in IDLE -> SoundSelect 100 next cycle; 000 after 12 frame ticks; busy tracks.
REQ-036 (QUEUE_EN) 5 coin pulses within the first frame -> pending saturates at 3; four chimes of 12 ticks each, with a 1-cycle 000 gap between chimes.
REQ-037 Coin playing, status goes 00100->00010 -> SoundSelect 010 next cycle, pending 0; 000 after 180 ticks.
REQ-038 Win and lose bits rise in the same cycle -> SoundSelect 001.
REQ-039 In WIN, status[1] falls after 50 ticks -> SoundSelect 000 next cycle, busy 0.
REQ-040 Reset asserted mid-COIN with pending 2 -> outputs 000/0/0 immediately; no chime after release while coin_collide is held high.
